baud_tick_gen: RTL and testbench

Parametrised, runtime-programmable successor to the fixed two-rate clock divider. From the single system clock it generates an oversample tick, a bit-rate tick, and a 50 %-duty bit-rate clock for the UART TX/RX paths. The divisor is loaded at runtime, switches glitch-free on a tick boundary, and the phase can be realigned mid-bit for start-bit sampling.

---
 rtl/baud_tick_pkg.sv | 14 +
 rtl/mod_counter.sv | 29 ++
 rtl/baud_tick_gen.sv | 104 ++++++++++
 tb/tb_baud_tick_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_tick_pkg.sv
// Shared constants, types and helpers for the baud tick generator.
package baud_tick_pkg;

  localparam int MIN_DIV       = 2;
  localparam int DEFAULT_DIV_W = 16;

  typedef logic [DEFAULT_DIV_W-1:0] div_t;

  // Clock cycles per oversample tick for a given clock, baud rate and oversample factor.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return clk_hz / (baud * ovs);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Generic modulo counter: counts 0..lastValue while run is high, clear loads loadValue.
module mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             inClock,
  input  logic             inResetN,
  input  logic             run,
  input  logic             clear,
  input  logic [WIDTH-1:0] loadValue,
  input  logic [WIDTH-1:0] lastValue,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // A clear always wins, so a coincident wrap is swallowed.
  assign wrap = run && !clear && (count == lastValue);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge inClock or negedge inResetN) begin
    if (!inResetN) begin
      count <= '0;
    end else if (clear) begin
      count <= loadValue;
    end else if (run) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Runtime-programmable oversample/bit-rate tick and bit clock generator for the UART paths.
module baud_tick_gen
  import baud_tick_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = DEFAULT_DIV_W,
  parameter int DEFAULT_DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE)
) (
  input  logic             inClock,
  input  logic             inResetN,
  input  logic             enable,
  input  logic             restart,
  input  logic             divLoad,
  input  logic [DIV_W-1:0] divValue,
  output logic             ovsTick,
  output logic             bitTick,
  output logic             outClock,
  output logic             divPending,
  output logic             divErr
);

  localparam int               OVS_W     = $clog2(OVERSAMPLE);
  localparam logic [OVS_W-1:0] OVS_HALF  = OVS_W'(OVERSAMPLE / 2);
  localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] pending_div;
  logic [DIV_W-1:0] pend_next;
  logic [DIV_W-1:0] div_cnt_unused;
  logic [OVS_W-1:0] ovs_cnt;
  logic             div_wrap;
  logic             ovs_wrap;
  logic             load_ok;
  logic             pend_avail;
  logic             apply_now;
  logic             div_clear;

  assign load_ok    = divLoad && (divValue >= DIV_W'(MIN_DIV));
  assign pend_avail = load_ok || divPending;
  assign pend_next  = load_ok ? divValue : pending_div;
  assign apply_now  = pend_avail && (div_wrap || restart || !enable);
  // Applying while idle restarts the period so it never mixes old and new divisors.
  assign div_clear  = restart || (!enable && pend_avail);

  mod_counter #(.WIDTH(DIV_W)) u_div_cnt (
    .inClock   (inClock),
    .inResetN  (inResetN),
    .run       (enable),
    .clear     (div_clear),
    .loadValue ('0),
    .lastValue (active_div - DIV_W'(1)),
    .count     (div_cnt_unused),
    .wrap      (div_wrap)
  );

  mod_counter #(.WIDTH(OVS_W)) u_ovs_cnt (
    .inClock   (inClock),
    .inResetN  (inResetN),
    .run       (div_wrap),
    .clear     (restart),
    .loadValue (OVS_HALF),
    .lastValue (OVS_LAST),
    .count     (ovs_cnt),
    .wrap      (ovs_wrap)
  );

  always_ff @(posedge inClock or negedge inResetN) begin
    if (!inResetN) begin
      ovsTick  <= 1'b0;
      bitTick  <= 1'b0;
      outClock <= 1'b0;
      divErr   <= 1'b0;
    end else begin
      ovsTick <= div_wrap;
      bitTick <= ovs_wrap;
      divErr  <= divLoad && !load_ok;
      if (restart) begin
        outClock <= 1'b1;
      end else if (div_wrap && (ovs_cnt == OVS_LAST || ovs_cnt == OVS_HALF - OVS_W'(1))) begin
        outClock <= ~outClock;
      end
    end
  end

  always_ff @(posedge inClock or negedge inResetN) begin
    if (!inResetN) begin
      active_div  <= DIV_RESET;
      pending_div <= DIV_RESET;
      divPending  <= 1'b0;
    end else begin
      if (load_ok) pending_div <= divValue;
      if (apply_now) begin
        active_div <= pend_next;
        divPending <= 1'b0;
      end else if (load_ok) begin
        divPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_baud_tick_gen;
  import baud_tick_pkg::*;

  localparam int OVS  = 4;
  localparam int DDIV = 4;

  logic inClock  = 1'b0;
  logic inResetN = 1'b0;
  logic enable   = 1'b0;
  logic restart  = 1'b0;
  logic divLoad  = 1'b0;
  div_t divValue = '0;
  logic ovsTick, bitTick, outClock, divPending, divErr;

  int errors = 0;
  int checks = 0;

  always #5 inClock = ~inClock;

  baud_tick_gen #(
    .CLK_HZ      (50000000),
    .BAUD        (9600),
    .OVERSAMPLE  (OVS),
    .DIV_W       (DEFAULT_DIV_W),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .inClock    (inClock),
    .inResetN   (inResetN),
    .enable     (enable),
    .restart    (restart),
    .divLoad    (divLoad),
    .divValue   (divValue),
    .ovsTick    (ovsTick),
    .bitTick    (bitTick),
    .outClock   (outClock),
    .divPending (divPending),
    .divErr     (divErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles left until the next oversample tick, position within the bit,
  // and the divisor bookkeeping. The bit clock is high in the second half of the bit.
  int m_active    = DDIV;
  int m_pending   = DDIV;
  int m_remaining = DDIV;
  int m_idx       = 0;
  bit m_pvalid    = 1'b0;
  bit e_ovs, e_bit, e_err;

  task automatic model_step();
    int  v;
    int  nd;
    bit  ld_ok, have, boundary, fresh;
    e_ovs = 1'b0;
    e_bit = 1'b0;
    e_err = 1'b0;
    if (!inResetN) begin
      m_active    = DDIV;
      m_pending   = DDIV;
      m_pvalid    = 1'b0;
      m_remaining = DDIV;
      m_idx       = 0;
      return;
    end
    v        = int'(divValue);
    ld_ok    = divLoad && v >= MIN_DIV;
    e_err    = divLoad && v < MIN_DIV;
    have     = ld_ok || m_pvalid;
    nd       = ld_ok ? v : m_pending;
    boundary = 1'b0;
    fresh    = 1'b0;
    if (ld_ok) m_pending = v;
    if (restart) begin
      m_idx    = OVS / 2;
      boundary = 1'b1;
      fresh    = 1'b1;
    end else if (enable) begin
      if (m_remaining == 1) begin
        e_ovs    = 1'b1;
        m_idx    = (m_idx + 1) % OVS;
        e_bit    = (m_idx == 0);
        boundary = 1'b1;
        fresh    = 1'b1;
      end else begin
        m_remaining--;
      end
    end else begin
      boundary = 1'b1;
      fresh    = have;
    end
    if (boundary && have) begin
      m_active = nd;
      m_pvalid = 1'b0;
    end else if (ld_ok) begin
      m_pvalid = 1'b1;
    end
    if (fresh) m_remaining = m_active;
  endtask

  initial begin
    forever begin
      @(posedge inClock);
      #1;
      model_step();
      check("m_ovsTick", ovsTick, e_ovs);
      check("m_bitTick", bitTick, e_bit);
      check("m_outClock", outClock, (m_idx >= OVS / 2));
      check("m_divPending", divPending, m_pvalid);
      check("m_divErr", divErr, e_err);
    end
  end

  task automatic at_edge();
    @(posedge inClock);
    #2;
  endtask

  task automatic wait_ovs(output int n);
    n = 0;
    do begin
      at_edge();
      n++;
    end while (!ovsTick && n < 64);
    if (!ovsTick) begin
      checks++;
      errors++;
      $display("FAIL wait_ovs: got no ovsTick expected one within 64 cycles");
    end
  endtask

  task automatic wait_bit(output int n);
    n = 0;
    do begin
      at_edge();
      n++;
    end while (!bitTick && n < 64);
    if (!bitTick) begin
      checks++;
      errors++;
      $display("FAIL wait_bit: got no bitTick expected one within 64 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge inClock);
    inResetN = 1'b0;
    #1;
    check("rst_ovsTick", ovsTick, 0);
    check("rst_bitTick", bitTick, 0);
    check("rst_outClock", outClock, 0);
    check("rst_divPending", divPending, 0);
    check("rst_divErr", divErr, 0);
    repeat (2) @(negedge inClock);
    inResetN = 1'b1;
  endtask

  initial begin
    int  n;
    logic c0;

    // Reset release with enable high: literal tick/clock schedule.
    enable = 1'b1;
    repeat (2) @(negedge inClock);
    inResetN = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      at_edge();
      check("s1_ovsTick", ovsTick, (e % 4 == 0));
      check("s1_bitTick", bitTick, (e == 16));
      check("s1_outClock", outClock, (e >= 8 && e < 16));
    end

    // Load 6 at divCnt=1: one more 4-cycle period, then 6-cycle periods.
    at_edge();
    @(negedge inClock);
    divLoad  = 1'b1;
    divValue = 16'd6;
    at_edge();
    check("s2_pend_set", divPending, 1);
    @(negedge inClock);
    divLoad  = 1'b0;
    divValue = '0;
    wait_ovs(n);
    check("s2_first_period", n, 2);
    check("s2_pend_clr", divPending, 0);
    wait_ovs(n);
    check("s2_period6_a", n, 6);
    wait_ovs(n);
    check("s2_period6_b", n, 6);

    // Rejected loads of 1 and 0.
    do_reset();
    wait_ovs(n);
    check("s3_reset_period", n, 4);
    for (int k = 1; k >= 0; k--) begin
      @(negedge inClock);
      divLoad  = 1'b1;
      divValue = div_t'(k);
      at_edge();
      check("s3_err_pulse", divErr, 1);
      check("s3_no_pend", divPending, 0);
      @(negedge inClock);
      divLoad = 1'b0;
      at_edge();
      check("s3_err_single", divErr, 0);
    end
    wait_ovs(n);
    wait_ovs(n);
    check("s3_period_kept", n, 4);

    // Restart on the very cycle a wrap would occur.
    wait_ovs(n);
    repeat (3) at_edge();
    @(negedge inClock);
    restart = 1'b1;
    at_edge();
    check("s4_no_tick", ovsTick, 0);
    check("s4_clk_high", outClock, 1);
    @(negedge inClock);
    restart = 1'b0;
    wait_bit(n);
    check("s4_bit_delay", n, 8);
    check("s4_clk_fall", outClock, 0);
    check("s4_ovs_with_bit", ovsTick, 1);

    // Enable dropped for 5 cycles one cycle into a period.
    wait_ovs(n);
    at_edge();
    c0 = outClock;
    @(negedge inClock);
    enable = 1'b0;
    repeat (5) begin
      at_edge();
      check("s5_no_ovs", ovsTick, 0);
      check("s5_no_bit", bitTick, 0);
      check("s5_clk_hold", outClock, c0);
    end
    @(negedge inClock);
    enable = 1'b1;
    wait_ovs(n);
    check("s5_remaining", n, 3);

    // Reset while a load is pending discards it.
    wait_ovs(n);
    at_edge();
    @(negedge inClock);
    divLoad  = 1'b1;
    divValue = 16'd6;
    at_edge();
    check("s6_pend_set", divPending, 1);
    @(negedge inClock);
    divLoad  = 1'b0;
    divValue = '0;
    do_reset();
    wait_ovs(n);
    check("s6_period_a", n, 4);
    wait_ovs(n);
    check("s6_period_b", n, 4);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge inClock);
      enable   = ($urandom_range(0, 9) != 0);
      restart  = ($urandom_range(0, 29) == 0);
      divLoad  = ($urandom_range(0, 19) == 0);
      divValue = div_t'($urandom_range(0, 7));
      inResetN = ($urandom_range(0, 499) != 0);
    end
    @(negedge inClock);
    inResetN = 1'b1;
    enable   = 1'b1;
    restart  = 1'b0;
    divLoad  = 1'b0;
    repeat (2) at_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
